decimal_entry: RTL

DECIMAL_ENTRY -- requirements
Module: decimal_entry

---
 rtl/decimal_entry.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/decimal_entry.sv
// Three-digit decimal keypad entry: synchronized, edge-detected pushbuttons drive a BCD accumulator.
// Define DECIMAL_ENTRY_DEBOUNCE_EN to compile in the per-key DEB_CYCLES debounce counters.
`timescale 1ns/1ps

module decimal_entry #(
    parameter int unsigned DEB_CYCLES = 50000
) (
    input  logic       CLOCK_50,
    input  logic       RST,
    input  logic [3:0] SW,
    input  logic [3:0] KEY,
    output logic [9:0] ACC,
    output logic [9:0] VALUE,
    output logic       VALID,
    output logic [1:0] CNT,
    output logic       ERR
);

    logic [3:0] key_s1_q;
    logic [3:0] key_s2_q;
    logic [1:0] prime_q;
    logic [3:0] armed_q;
    logic [3:0] lvl_prev_q;
    logic [3:0] level_s;
    logic [3:0] press_s;

    logic [9:0] acc_q,   acc_d;
    logic [9:0] value_q, value_d;
    logic       valid_q, valid_d;
    logic [1:0] cnt_q,   cnt_d;
    logic       err_q,   err_d;

    // Key synchronizer, edge-detect history and post-reset arming.
    // A key is armed only after a genuine released sample has passed through the
    // synchronizer, so a button held across reset cannot generate a press.
    always_ff @(posedge CLOCK_50 or posedge RST) begin
        if (RST) begin
            key_s1_q   <= 4'hF;
            key_s2_q   <= 4'hF;
            prime_q    <= 2'b00;
            armed_q    <= 4'h0;
            lvl_prev_q <= 4'hF;
        end else begin
            key_s1_q   <= KEY;
            key_s2_q   <= key_s1_q;
            prime_q    <= {prime_q[0], 1'b1};
            armed_q    <= armed_q | ({4{prime_q[1]}} & key_s2_q);
            lvl_prev_q <= level_s;
        end
    end

`ifdef DECIMAL_ENTRY_DEBOUNCE_EN
    localparam int unsigned       DCW      = $clog2(DEB_CYCLES + 1);
    localparam logic [DCW-1:0]    DEB_LAST = DCW'(DEB_CYCLES - 1);

    logic [3:0]          deb_q, deb_d;
    logic [3:0][DCW-1:0] dcnt_q, dcnt_d;

    // Accept a new level only after DEB_CYCLES consecutive differing samples.
    always_comb begin
        deb_d  = deb_q;
        dcnt_d = dcnt_q;
        for (int i = 0; i < 4; i++) begin
            if (key_s2_q[i] == deb_q[i]) begin
                dcnt_d[i] = {DCW{1'b0}};
            end else if (dcnt_q[i] == DEB_LAST) begin
                deb_d[i]  = key_s2_q[i];
                dcnt_d[i] = {DCW{1'b0}};
            end else begin
                dcnt_d[i] = dcnt_q[i] + DCW'(1);
            end
        end
    end

    // Debounce state register.
    always_ff @(posedge CLOCK_50 or posedge RST) begin
        if (RST) begin
            deb_q  <= 4'hF;
            dcnt_q <= {(4*DCW){1'b0}};
        end else begin
            deb_q  <= deb_d;
            dcnt_q <= dcnt_d;
        end
    end

    assign level_s = deb_q;
`else
    assign level_s = key_s2_q;

    // DEB_CYCLES has no effect in this build; a zero value is still tolerated.
    if (DEB_CYCLES == 32'd0) begin : g_deb_cycles_unused
    end
`endif

    assign press_s = lvl_prev_q & ~level_s & armed_q;

    // Event resolution: clear > commit > backspace > digit.
    always_comb begin
        acc_d   = acc_q;
        value_d = value_q;
        valid_d = 1'b0;
        cnt_d   = cnt_q;
        err_d   = err_q;
        if (press_s[3]) begin
            acc_d = 10'd0;
            cnt_d = 2'd0;
            err_d = 1'b0;
        end else if (press_s[2]) begin
            if (cnt_q != 2'd0) begin
                value_d = acc_q;
                valid_d = 1'b1;
                acc_d   = 10'd0;
                cnt_d   = 2'd0;
                err_d   = 1'b0;
            end else begin
                err_d = 1'b1;
            end
        end else if (press_s[1]) begin
            if (cnt_q != 2'd0) begin
                acc_d = acc_q / 10'd10;
                cnt_d = cnt_q - 2'd1;
                err_d = 1'b0;
            end else begin
                err_d = 1'b1;
            end
        end else if (press_s[0]) begin
            if (SW > 4'd9) begin
                err_d = 1'b1;
            end else if (cnt_q == 2'd3) begin
                err_d = 1'b1;
            end else begin
                // With fewer than three digits the accumulator is at most 99, so this stays <= 999.
                acc_d = (acc_q * 10'd10) + {6'd0, SW};
                cnt_d = cnt_q + 2'd1;
                err_d = 1'b0;
            end
        end else begin
            valid_d = 1'b0;
        end
    end

    // Registered accumulator and output state.
    always_ff @(posedge CLOCK_50 or posedge RST) begin
        if (RST) begin
            acc_q   <= 10'd0;
            value_q <= 10'd0;
            valid_q <= 1'b0;
            cnt_q   <= 2'd0;
            err_q   <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            value_q <= value_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign ACC   = acc_q;
    assign VALUE = value_q;
    assign VALID = valid_q;
    assign CNT   = cnt_q;
    assign ERR   = err_q;

endmodule
